spi_slave_driver: RTL and testbench

SPI_SLAVE_DRIVER -- requirements
Module: spi_slave_driver

---
 rtl/spi_slave_driver.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_driver.sv
// rtl/spi_slave_driver.sv - SPI mode-0 slave with synchronised, debounced pins
// Words are captured from tx_data on tx_load and presented on rx_data with rx_valid.
module spi_slave_driver #(
  parameter int DATA_WIDTH    = 8,
  parameter int BOUNCE_FILTER = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  busy,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  sclk,
  input  logic                  cs
);
  localparam int FW     = $clog2(BOUNCE_FILTER + 1);
  localparam int CW     = $clog2(DATA_WIDTH);
  localparam int SETTLE = BOUNCE_FILTER + 3;
  localparam int SW     = $clog2(SETTLE + 1);
  // Pin vectors are ordered {cs, sclk, mosi}; cs idles high.
  localparam logic [2:0] PIN_RST = 3'b100;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state, state_nx;
  logic [2:0]            sync1, sync2, filt;
  logic [2:1]            filt_d;
  logic [FW-1:0]         cnt [3];
  logic                  cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [SW-1:0]         settle_cnt;
  logic                  armed;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [CW-1:0]         bit_cnt;
  logic                  word_done;
  logic                  start_ev, reload_ev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= PIN_RST;
      sync2  <= PIN_RST;
      filt   <= PIN_RST;
      filt_d <= PIN_RST[2:1];
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1  <= {cs, sclk, mosi};
      sync2  <= sync1;
      filt_d <= filt[2:1];
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == FW'(BOUNCE_FILTER - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign cs_rise   =  filt[2] & ~filt_d[2];
  assign cs_fall   = ~filt[2] &  filt_d[2];
  assign sclk_rise =  filt[1] & ~filt_d[1];
  assign sclk_fall = ~filt[1] &  filt_d[1];
  assign rx_next   = {rx_shift, filt[0]};

  // A frame already in progress when reset lifts is not joined: cs must be
  // seen high (after the pipeline settles, or via a rise) before a fall counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != SW'(SETTLE)) begin
        settle_cnt <= settle_cnt + 1'b1;
        if (settle_cnt == SW'(SETTLE - 1) && filt[2]) armed <= 1'b1;
      end
      if (cs_rise) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (cs_fall && armed) state_nx = SHIFT;
      SHIFT: if (cs_rise)          state_nx = IDLE;
    endcase
  end

  always_comb begin
    start_ev  = 1'b0;
    reload_ev = 1'b0;
    frame_end = 1'b0;
    busy      = 1'b0;
    miso      = 1'b0;
    case (state)
      IDLE:  start_ev = cs_fall & armed;
      SHIFT: begin
        busy      = 1'b1;
        miso      = tx_shift[DATA_WIDTH-1];
        frame_end = cs_rise;
        reload_ev = ~cs_rise & sclk_fall & word_done;
      end
    endcase
  end

  assign tx_load     = start_ev | reload_ev;
  assign frame_start = start_ev;

  // cs rise wins over any sclk edge in the same cycle and drops a partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start_ev) begin
        tx_shift  <= tx_data;
        rx_shift  <= '0;
        bit_cnt   <= '0;
        word_done <= 1'b0;
      end else if (state == SHIFT && cs_rise) begin
        bit_cnt   <= '0;
        word_done <= 1'b0;
      end else if (state == SHIFT && sclk_rise) begin
        rx_shift <= rx_next[DATA_WIDTH-2:0];
        if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
          rx_data   <= rx_next;
          rx_valid  <= 1'b1;
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (state == SHIFT && sclk_fall) begin
        if (word_done) begin
          tx_shift  <= tx_data;
          word_done <= 1'b0;
        end else begin
          tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_driver.sv
// tb/tb_spi_slave_driver.sv - directed bench for spi_slave_driver
// dut1 uses BOUNCE_FILTER=1; dut2 (BOUNCE_FILTER=3) shares the pins plus glitch injection.
`timescale 1ns/1ps
module tb_spi_slave_driver;
  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mosi = 1'b0, sclk = 1'b0, cs = 1'b1;
  logic       g_sclk = 1'b0, g_cs = 1'b0;
  logic       sclk2, cs2;
  logic [7:0] tx_data;
  logic       tx_load, rx_valid, frame_start, frame_end, busy, miso;
  logic [7:0] rx_data;
  logic       tx_load2, rx_valid2, frame_start2, frame_end2, busy2, miso2;
  logic [7:0] rx_data2;

  int errors = 0, checks = 0;

  assign sclk2 = sclk | g_sclk;
  assign cs2   = cs | g_cs;

  always #5 clk = ~clk;

  spi_slave_driver #(.DATA_WIDTH(8), .BOUNCE_FILTER(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_start(frame_start), .frame_end(frame_end), .busy(busy),
    .mosi(mosi), .miso(miso), .sclk(sclk), .cs(cs));

  spi_slave_driver #(.DATA_WIDTH(8), .BOUNCE_FILTER(3)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_load(tx_load2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .frame_start(frame_start2), .frame_end(frame_end2), .busy(busy2),
    .mosi(mosi), .miso(miso2), .sclk(sclk2), .cs(cs2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmit words handed out in order, one per tx_load of dut1.
  logic [7:0] tx_words [8];
  int tx_loads = 0, tx_base = 0;
  always @(posedge clk) if (tx_load) tx_loads <= tx_loads + 1;
  assign tx_data = tx_words[3'(tx_loads - tx_base)];

  // Model: dut1 state follows the cs pin three samples late; words come from the bit stream.
  logic [3:0] cs_hist = 4'b1111;
  logic       armed_m = 1'b0;
  logic [7:0] exp_q1[$], exp_q2[$];
  logic [7:0] last_rx1 = 8'h00, last_rx2 = 8'h00;
  int n_fs1 = 0, n_fe1 = 0, n_rv1 = 0, n_fe2 = 0, n_rv2 = 0;

  always @(posedge clk) begin
    #1;
    cs_hist = {cs_hist[2:0], cs};
    if (!rst) begin
      armed_m  = 1'b0;
      last_rx1 = 8'h00;
      last_rx2 = 8'h00;
      check("reset_outputs", {busy, miso, rx_valid, tx_load, frame_start, frame_end, rx_data,
                              busy2, miso2, rx_valid2, tx_load2, frame_start2, frame_end2, rx_data2}, 64'h0);
    end else begin
      if (cs_hist[3]) armed_m = 1'b1;
      check("busy", busy, armed_m && !cs_hist[3]);
      check("frame_start", frame_start, armed_m && !cs_hist[2] && cs_hist[3]);
      check("frame_end", frame_end, armed_m && cs_hist[2] && !cs_hist[3]);
      if (!busy)  check("miso_idle", miso, 1'b0);
      if (!busy2) check("miso2_idle", miso2, 1'b0);
      if (rx_valid) begin
        if (exp_q1.size() == 0) check("rx_valid_unexpected", rx_valid, 1'b0);
        else last_rx1 = exp_q1.pop_front();
      end
      if (rx_valid2) begin
        if (exp_q2.size() == 0) check("rx_valid2_unexpected", rx_valid2, 1'b0);
        else last_rx2 = exp_q2.pop_front();
      end
      check("rx_data", rx_data, last_rx1);
      check("rx_data2", rx_data2, last_rx2);
      n_fs1 += int'(frame_start);
      n_fe1 += int'(frame_end);
      n_rv1 += int'(rx_valid);
      n_fe2 += int'(frame_end2);
      n_rv2 += int'(rx_valid2);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // end_mode 0: cs stays low; 1: cs rises with the last sclk fall; 2: cs rises with an extra sclk rise.
  task automatic run_frame(input logic [63:0] mo, input int nbits, input int end_mode,
                           input bit glitch, output logic [63:0] mi);
    logic [7:0] w;
    tx_base = tx_loads;
    for (int i = 0; i < nbits / 8; i++) begin
      w = mo[nbits - 1 - 8 * i -: 8];
      exp_q1.push_back(w);
      exp_q2.push_back(w);
    end
    mi = '0;
    cs = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      mosi = mo[nbits - 1 - k];
      wait_clk(HP);
      mi = {mi[62:0], miso};
      sclk = 1'b1;
      wait_clk(HP);
      sclk = 1'b0;
      if (k == nbits - 1 && end_mode == 1) cs = 1'b1;
      if (glitch && k == 2) begin
        wait_clk(6);
        g_cs = 1'b1;
        wait_clk(1);
        g_cs = 1'b0;
        wait_clk(3);
        g_sclk = 1'b1;
        wait_clk(2);
        g_sclk = 1'b0;
        wait_clk(6);
      end
    end
    if (end_mode == 2) begin
      mosi = 1'b1;
      wait_clk(HP);
      sclk = 1'b1;
      cs   = 1'b1;
      wait_clk(HP);
      sclk = 1'b0;
    end
    wait_clk(14);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] mi;
    int b_ld, b_rv, b_fs, b_fe, b_fe2, b_rv2;
    for (int i = 0; i < 8; i++) tx_words[i] = 8'h00;
    #2 rst = 1'b0;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(20);
    check("rx_data_after_reset", rx_data, 8'h00);

    // Single word
    tx_words[0] = 8'hCC;
    b_ld = tx_loads; b_rv = n_rv1; b_fs = n_fs1; b_fe = n_fe1;
    run_frame(64'hA5, 8, 1, 1'b0, mi);
    check("single_miso", mi[7:0], 8'hCC);
    check("single_rx", rx_data, 8'hA5);
    check("single_tx_load", tx_loads - b_ld, 1);
    check("single_rx_valid", n_rv1 - b_rv, 1);
    check("single_frame_start", n_fs1 - b_fs, 1);
    check("single_frame_end", n_fe1 - b_fe, 1);

    // Back-to-back words in one frame
    for (int i = 0; i < 8; i++) tx_words[i] = 8'hB0 + 8'(i);
    b_ld = tx_loads; b_rv = n_rv1;
    run_frame(64'hA0A1A2A3A4A5A6A7, 64, 1, 1'b0, mi);
    check("b2b_miso", mi, 64'hB0B1B2B3B4B5B6B7);
    check("b2b_tx_load", tx_loads - b_ld, 8);
    check("b2b_rx_valid", n_rv1 - b_rv, 8);
    check("b2b_last_rx", rx_data, 8'hA7);

    // Partial word, then cs rising together with an sclk rise, then a clean word
    tx_words[0] = 8'h5A;
    b_rv = n_rv1; b_fe = n_fe1; b_ld = tx_loads;
    run_frame(64'h16, 5, 1, 1'b0, mi);
    check("partial_miso", mi[4:0], 5'h0B);
    check("partial_rx_valid", n_rv1 - b_rv, 0);
    check("partial_rx_kept", rx_data, 8'hA7);
    check("partial_frame_end", n_fe1 - b_fe, 1);
    check("partial_tx_load", tx_loads - b_ld, 1);
    b_rv = n_rv1;
    run_frame(64'h55, 7, 2, 1'b0, mi);
    check("cs_priority_rx_valid", n_rv1 - b_rv, 0);
    check("cs_priority_rx_kept", rx_data, 8'hA7);
    tx_words[0] = 8'h81;
    run_frame(64'h69, 8, 1, 1'b0, mi);
    check("after_partial_rx", rx_data, 8'h69);
    check("after_partial_miso", mi[7:0], 8'h81);

    // Glitches seen only by dut2
    b_fe2 = n_fe2; b_rv2 = n_rv2;
    run_frame(64'hC3, 8, 1, 1'b1, mi);
    check("glitch_rx2", rx_data2, 8'hC3);
    check("glitch_rx_valid2", n_rv2 - b_rv2, 1);
    check("glitch_frame_end2", n_fe2 - b_fe2, 1);

    // sclk activity with cs high
    b_rv = n_rv1; b_ld = tx_loads; b_fs = n_fs1;
    for (int i = 0; i < 16; i++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      wait_clk(HP);
    end
    wait_clk(8);
    check("idle_rx_valid", n_rv1 - b_rv, 0);
    check("idle_tx_load", tx_loads - b_ld, 0);
    check("idle_frame_start", n_fs1 - b_fs, 0);

    // Reset mid-frame with cs held low
    tx_words[0] = 8'h96;
    run_frame(64'h5, 3, 0, 1'b0, mi);
    rst = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    b_rv = n_rv1; b_ld = tx_loads; b_fs = n_fs1;
    for (int i = 0; i < 8; i++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      wait_clk(HP);
    end
    wait_clk(8);
    check("post_reset_rx_valid", n_rv1 - b_rv, 0);
    check("post_reset_tx_load", tx_loads - b_ld, 0);
    check("post_reset_frame_start", n_fs1 - b_fs, 0);
    check("post_reset_rx_data", rx_data, 8'h00);
    cs = 1'b1;
    wait_clk(12);
    tx_words[0] = 8'hE1;
    run_frame(64'h3C, 8, 1, 1'b0, mi);
    check("post_reset_word", rx_data, 8'h3C);
    check("post_reset_word2", rx_data2, 8'h3C);
    check("post_reset_miso", mi[7:0], 8'hE1);

    check("queue1_drained", 64'(exp_q1.size()), 64'd0);
    check("queue2_drained", 64'(exp_q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
